angle_normalization_fp_adder: RTL and testbench

- Responder end of the add_a/add_b/add_start → add_sum/add_ready handshake that the angle normalization core and other FP sequencers use as initiators.
- Multi-cycle IEEE-754-style floating-point adder with round-to-nearest-even and denormal flush-to-zero.
- Fixed latency, one operation in flight; sits beside the normalization wrapper and is wired directly to its adder ports.

---
 rtl/angle_normalization_fp_adder.sv | 195 +++++++++++++++++++
 tb/tb_angle_normalization_fp_adder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/angle_normalization_fp_adder.sv
// Multi-cycle floating-point adder (RNE rounding, denormals flushed to zero) answering the
// add_start/add_ready handshake. One operation in flight, fixed five-cycle latency.
module angle_normalization_fp_adder #(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            add_start,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_a,
    input  logic [EXP_LEN+MANTISSA_LEN:0]   add_b,
    output logic [EXP_LEN+MANTISSA_LEN:0]   add_sum,
    output logic                            add_ready,
    output logic                            add_busy
);

    localparam int W     = EXP_LEN + MANTISSA_LEN + 1;
    localparam int SIG_W = MANTISSA_LEN + 1;
    localparam int EXT_W = SIG_W + 3;
    localparam int SUM_W = EXT_W + 1;
    localparam int EW    = EXP_LEN + 2;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] ADD   = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] ROUND = 3'd4;

    localparam logic [EXP_LEN-1:0]   SHIFT_MAX = EXP_LEN'(MANTISSA_LEN + 3);
    localparam logic signed [EW-1:0] E_ONE     = EW'(1);
    localparam logic signed [EW-1:0] E_ZERO    = '0;
    localparam logic signed [EW-1:0] E_MAX     = EW'((1 << EXP_LEN) - 1);
    localparam logic [W-1:0]         QNAN      = {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

    logic [2:0]              state;
    logic [W-1:0]            op_a, op_b;
    logic                    sign_p0, sub_p0, spec_p0;
    logic [EXP_LEN-1:0]      exp_p0;
    logic [EXT_W-1:0]        big_p0, small_p0;
    logic [W-1:0]            spec_val_p0;
    logic [SUM_W-1:0]        sum_p1;
    logic [EXT_W-1:0]        sig_p2;
    logic signed [EW-1:0]    exp_p2;
    logic                    zero_p2;

    function automatic logic [W-2:0] mag(input logic [W-2:0] x);
        return (x[W-2:MANTISSA_LEN] == '0) ? '0 : x;
    endfunction

    function automatic logic [SIG_W-1:0] sig_of(input logic [EXP_LEN-1:0] e,
                                                 input logic [MANTISSA_LEN-1:0] f);
        return (e == '0) ? '0 : {1'b1, f};
    endfunction

    function automatic logic [EW-1:0] lzc(input logic [EXT_W-1:0] v);
        logic [EW-1:0] cnt;
        logic          found;
        cnt   = '0;
        found = 1'b0;
        for (int i = EXT_W - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt = cnt + EW'(1);
            end
        end
        return cnt;
    endfunction

    // Round-to-nearest-even on {sig, G, R, S}; overflow to inf and underflow flush to zero.
    function automatic logic [W-1:0] round_pack(input logic sign,
                                                input logic signed [EW-1:0] e_in,
                                                input logic [EXT_W-1:0] sig);
        logic                    inc, ovf;
        logic [MANTISSA_LEN-1:0] frac;
        logic signed [EW-1:0]    e;
        inc  = sig[2] & (sig[1] | sig[0] | sig[3]);
        ovf  = inc & (&sig[EXT_W-1:3]);
        frac = sig[MANTISSA_LEN+2:3] + {{(MANTISSA_LEN-1){1'b0}}, inc};
        e    = ovf ? e_in + E_ONE : e_in;
        if (e >= E_MAX)       return {sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        else if (e <= E_ZERO) return {sign, {(W-1){1'b0}}};
        else                  return {sign, e[EXP_LEN-1:0], frac};
    endfunction

    logic [EXP_LEN-1:0]      exp_a, exp_b, exp_big, exp_small, diff;
    logic                    nan_a, nan_b, inf_a, inf_b, swap, sign_big, spec_c;
    logic [EXT_W-1:0]        big_ext, small_ext, small_al;
    logic [W-1:0]            spec_val_c;
    logic [SUM_W-1:0]        sum_c;
    logic [EW-1:0]           lz;
    logic [EXT_W-1:0]        sig_c;
    logic signed [EW-1:0]    exp_c;

    always_comb begin
        exp_a      = op_a[W-2:MANTISSA_LEN];
        exp_b      = op_b[W-2:MANTISSA_LEN];
        nan_a      = (&exp_a) & (|op_a[MANTISSA_LEN-1:0]);
        nan_b      = (&exp_b) & (|op_b[MANTISSA_LEN-1:0]);
        inf_a      = (&exp_a) & ~(|op_a[MANTISSA_LEN-1:0]);
        inf_b      = (&exp_b) & ~(|op_b[MANTISSA_LEN-1:0]);
        swap       = mag(op_b[W-2:0]) > mag(op_a[W-2:0]);
        sign_big   = swap ? op_b[W-1] : op_a[W-1];
        exp_big    = swap ? exp_b : exp_a;
        exp_small  = swap ? exp_a : exp_b;
        diff       = exp_big - exp_small;
        big_ext    = {(swap ? sig_of(exp_b, op_b[MANTISSA_LEN-1:0])
                            : sig_of(exp_a, op_a[MANTISSA_LEN-1:0])), 3'b000};
        small_ext  = {(swap ? sig_of(exp_a, op_a[MANTISSA_LEN-1:0])
                            : sig_of(exp_b, op_b[MANTISSA_LEN-1:0])), 3'b000};
        if (diff >= SHIFT_MAX)
            small_al = {{(EXT_W-1){1'b0}}, |small_ext};
        else
            small_al = (small_ext >> diff)
                     | {{(EXT_W-1){1'b0}}, |(small_ext & ~({EXT_W{1'b1}} << diff))};
        spec_c     = nan_a | nan_b | inf_a | inf_b;
        if (nan_a | nan_b | (inf_a & inf_b & (op_a[W-1] ^ op_b[W-1]))) spec_val_c = QNAN;
        else if (inf_a)                                                   spec_val_c = op_a;
        else                                                              spec_val_c = op_b;

        sum_c = sub_p0 ? ({1'b0, big_p0} - {1'b0, small_p0})
                       : ({1'b0, big_p0} + {1'b0, small_p0});

        lz = lzc(sum_p1[EXT_W-1:0]);
        if (sum_p1[SUM_W-1]) begin
            sig_c = {sum_p1[SUM_W-1:2], |sum_p1[1:0]};
            exp_c = $signed({2'b00, exp_p0}) + E_ONE;
        end else begin
            sig_c = sum_p1[EXT_W-1:0] << lz;
            exp_c = $signed({2'b00, exp_p0}) - $signed(lz);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            add_sum     <= '0;
            add_ready   <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            sign_p0     <= 1'b0;
            sub_p0      <= 1'b0;
            spec_p0     <= 1'b0;
            exp_p0      <= '0;
            big_p0      <= '0;
            small_p0    <= '0;
            spec_val_p0 <= '0;
            sum_p1      <= '0;
            sig_p2      <= '0;
            exp_p2      <= '0;
            zero_p2     <= 1'b0;
        end else begin
            add_ready <= 1'b0;
            case (state)
                IDLE: if (add_start) begin
                    op_a  <= add_a;
                    op_b  <= add_b;
                    state <= ALIGN;
                end
                // ALIGN -> ADD: operands ordered by magnitude, smaller shifted with GRS bits
                ALIGN: begin
                    sign_p0     <= sign_big;
                    sub_p0      <= op_a[W-1] ^ op_b[W-1];
                    exp_p0      <= exp_big;
                    big_p0      <= big_ext;
                    small_p0    <= small_al;
                    spec_p0     <= spec_c;
                    spec_val_p0 <= spec_val_c;
                    state       <= ADD;
                end
                ADD: begin
                    sum_p1 <= sum_c;
                    state  <= NORM;
                end
                NORM: begin
                    sig_p2  <= sig_c;
                    exp_p2  <= exp_c;
                    zero_p2 <= (sum_p1 == '0);
                    state   <= ROUND;
                end
                // ROUND -> IDLE: exact cancellation yields +0, same-sign zeros keep their sign
                ROUND: begin
                    add_ready <= 1'b1;
                    state     <= IDLE;
                    if (spec_p0)      add_sum <= spec_val_p0;
                    else if (zero_p2) add_sum <= {sign_p0 & ~sub_p0, {(W-1){1'b0}}};
                    else              add_sum <= round_pack(sign_p0, exp_p2, sig_p2);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign add_busy = (state != IDLE);

endmodule

// File: tb/tb_angle_normalization_fp_adder.sv
// Directed bench for angle_normalization_fp_adder: arithmetic vectors, latency,
// start handshake and mid-operation reset.
module tb_angle_normalization_fp_adder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        add_start;
    logic [31:0] add_a, add_b;
    logic [31:0] add_sum;
    logic        add_ready;
    logic        add_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    angle_normalization_fp_adder #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .add_start(add_start),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_sum  (add_sum),
        .add_ready(add_ready),
        .add_busy (add_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, want);
        end
    endtask

    // Issue one request and wait (bounded) for its result; latency must be 5.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
        int lat;
        bit seen;
        @(negedge clk);
        add_a = a; add_b = b; add_start = 1'b1;
        @(posedge clk);
        #1 add_start = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (add_ready) seen = 1'b1;
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check(tag, add_sum, want);
    endtask

    initial begin
        int cnt;
        logic [31:0] got_sum;

        reset_n = 1'b0; add_start = 1'b0; add_a = '0; add_b = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(add_ready), 32'd0);
        check("rst_busy",  32'(add_busy),  32'd0);
        check("rst_sum",   add_sum,        32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic add with cycle-by-cycle handshake checks
        @(negedge clk);
        add_a = 32'h3F800000; add_b = 32'h40000000; add_start = 1'b1;
        @(posedge clk);
        #1 add_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("basic_busy",  32'(add_busy),  32'd1);
            check("basic_noready", 32'(add_ready), 32'd0);
        end
        @(negedge clk);
        check("basic_ready", 32'(add_ready), 32'd1);
        check("basic_idle",  32'(add_busy),  32'd0);
        check("basic_sum",   add_sum,        32'h40400000);
        @(negedge clk);
        check("basic_pulse", 32'(add_ready), 32'd0);
        check("basic_hold",  add_sum,        32'h40400000);

        run_op("cancel",     32'h3F800000, 32'hBF800000, 32'h00000000);
        run_op("cancel_lsb", 32'h3F800001, 32'hBF800000, 32'h34000000);
        run_op("negzero",    32'h80000000, 32'h80000000, 32'h80000000);
        run_op("mixzero",    32'h00000000, 32'h80000000, 32'h00000000);
        run_op("tie_even",   32'h3F800000, 32'h33800000, 32'h3F800000);
        run_op("tie_odd",    32'h3F800001, 32'h33800000, 32'h3F800002);
        run_op("above_tie",  32'h3F800000, 32'h33800001, 32'h3F800001);
        run_op("overflow",   32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        run_op("inf_minf",   32'h7F800000, 32'hFF800000, 32'h7FC00000);
        run_op("nan_in",     32'h7FA00000, 32'h3F800000, 32'h7FC00000);
        run_op("minf_fin",   32'hFF800000, 32'h3F800000, 32'hFF800000);
        run_op("denorm",     32'h00000001, 32'h00000000, 32'h00000000);
        run_op("sub_swap",   32'h3F800000, 32'hC0000000, 32'hBF800000);

        // add_start held high with changing operands: only IDLE-cycle operands count
        for (int k = 0; k <= 15; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("hold_ready", 32'(add_ready), (k % 5 == 0) ? 32'd1 : 32'd0);
                if (k == 5)  check("hold_sum0", add_sum, 32'h40400000);
                if (k == 10) check("hold_sum1", add_sum, 32'h40000000);
                if (k == 15) check("hold_sum2", add_sum, 32'h40800000);
            end
            add_start = (k < 15);
            case (k)
                0:       begin add_a = 32'h3F800000; add_b = 32'h40000000; end
                5:       begin add_a = 32'h3F800000; add_b = 32'h3F800000; end
                10:      begin add_a = 32'h40000000; add_b = 32'h40000000; end
                default: begin add_a = 32'h7F800000; add_b = 32'hFF800000; end
            endcase
        end
        add_start = 1'b0;

        // A start pulse while busy is ignored
        @(negedge clk);
        add_a = 32'h40000000; add_b = 32'h40000000; add_start = 1'b1;
        @(posedge clk);
        #1 add_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        add_a = 32'h7FA00000; add_b = 32'h3F800000; add_start = 1'b1;
        @(posedge clk);
        #1 add_start = 1'b0;
        cnt = 0; got_sum = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (add_ready) begin cnt++; got_sum = add_sum; end
        end
        check("busy_start_cnt", 32'(cnt), 32'd1);
        check("busy_start_sum", got_sum,  32'h40800000);

        // Reset two cycles into an operation aborts it
        @(negedge clk);
        add_a = 32'h3F800000; add_b = 32'h40000000; add_start = 1'b1;
        @(posedge clk);
        #1 add_start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_ready", 32'(add_ready), 32'd0);
        check("abort_busy",  32'(add_busy),  32'd0);
        check("abort_sum",   add_sum,        32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (add_ready) cnt++;
        end
        check("abort_noready", 32'(cnt), 32'd0);
        run_op("after_reset", 32'h3F800000, 32'h40000000, 32'h40400000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
